// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: PC-select encoding,
// load-use FSM states and the bundled stall/flush control word.
package hazard_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_BRANCH = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } lu_state_e;

  // Per-cycle pipeline control word produced by the priority mux
  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/hazard_ctrl_v2_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline side,
// slave is the controller side.
interface hazard_ctrl_v2_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             if_id_rt_read;
  logic             if_id_mdu_use;
  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rt;
  logic             mdu_start;
  logic             dmem_req;
  logic             dmem_ready;
  logic             exc_req;
  logic             branch;
  logic             jump;
  logic             perf_clr;

  logic [1:0]       pc_src;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_mem_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_id_rs, if_id_rt, if_id_rt_read, if_id_mdu_use,
           id_ex_mem_read, id_ex_rt, mdu_start, dmem_req, dmem_ready,
           exc_req, branch, jump, perf_clr,
    input  pc_src, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mdu_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_rt_read, if_id_mdu_use,
           id_ex_mem_read, id_ex_rt, mdu_start, dmem_req, dmem_ready,
           exc_req, branch, jump, perf_clr,
    output pc_src, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mdu_busy, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides the increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_v2.sv
// Five-stage pipeline hazard controller: redirect priority, multi-cycle
// load-use interlock, MDU busy interlock, dmem freeze and perf counters.
module hazard_ctrl_v2
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  hazard_ctrl_v2_if.slave bus
);

  localparam int unsigned LU_W  = $clog2(LOAD_LAT + 1);
  localparam int unsigned MDU_W = $clog2(MDU_CYCLES + 1);

  localparam logic [LU_W-1:0]  LU_INIT  = LU_W'(LOAD_LAT - 1);
  localparam logic [MDU_W-1:0] MDU_INIT = MDU_W'(MDU_CYCLES);
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam bit               MULTI_LU = (LOAD_LAT > 1);

  lu_state_e        state;
  lu_state_e        state_next;
  logic [LU_W-1:0]  lu_cnt;
  logic [LU_W-1:0]  lu_cnt_next;
  logic [MDU_W-1:0] mdu_cnt;

  logic  load_use;
  logic  mem_wait;
  logic  redirect;
  logic  lu_active;
  logic  mdu_busy;
  ctrl_t ctrl;

  // Hazard detection; register 0 is hard-wired and can never hazard
  assign load_use = bus.id_ex_mem_read && (bus.id_ex_rt != REG_ZERO) &&
                    ((bus.id_ex_rt == bus.if_id_rs) ||
                     (bus.if_id_rt_read && (bus.id_ex_rt == bus.if_id_rt)));
  assign mem_wait  = bus.dmem_req && !bus.dmem_ready;
  assign redirect  = bus.exc_req || bus.branch || bus.jump;
  assign lu_active = (state == LU_STALL) || load_use;
  assign mdu_busy  = (mdu_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lu_cnt <= '0;
    end else begin
      state  <= state_next;
      lu_cnt <= lu_cnt_next;
    end
  end

  // The detection cycle counts as the first stall cycle; LU_STALL covers the rest
  always_comb begin
    state_next  = state;
    lu_cnt_next = lu_cnt;
    case (state)
      IDLE: begin
        if (!mem_wait && !redirect && load_use && MULTI_LU) begin
          state_next  = LU_STALL;
          lu_cnt_next = LU_INIT;
        end
      end
      LU_STALL: begin
        if (!mem_wait) begin
          if (redirect) begin
            state_next  = IDLE;
            lu_cnt_next = '0;
          end else begin
            lu_cnt_next = lu_cnt - LU_W'(1);
            if (lu_cnt == LU_W'(1)) begin
              state_next = IDLE;
            end
          end
        end
      end
      default: begin
        state_next  = IDLE;
        lu_cnt_next = '0;
      end
    endcase
  end

  // Priority mux; everything is held at zero while reset is asserted
  always_comb begin
    ctrl = CTRL_NONE;
    if (rst_n) begin
      if (mem_wait) begin
        ctrl.pc_src       = PCSRC_SEQ;
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_stall  = 1'b1;
        ctrl.ex_mem_stall = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
      end else if (bus.exc_req) begin
        ctrl.pc_src       = PCSRC_EXC;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
      end else if (bus.branch) begin
        ctrl.pc_src       = PCSRC_BRANCH;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
      end else if (bus.jump) begin
        ctrl.pc_src      = PCSRC_JUMP;
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if (lu_active || (mdu_busy && bus.if_id_mdu_use)) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  // MDU occupancy counter keeps running through memory freezes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (bus.mdu_start && !mdu_busy) begin
      mdu_cnt <= MDU_INIT;
    end else if (mdu_busy) begin
      mdu_cnt <= mdu_cnt - MDU_W'(1);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.pc_stall),
    .clr   (bus.perf_clr),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.if_id_flush),
    .clr   (bus.perf_clr),
    .count (bus.flush_cnt)
  );

  assign bus.pc_src       = ctrl.pc_src;
  assign bus.pc_stall     = ctrl.pc_stall;
  assign bus.if_id_stall  = ctrl.if_id_stall;
  assign bus.id_ex_stall  = ctrl.id_ex_stall;
  assign bus.ex_mem_stall = ctrl.ex_mem_stall;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.ex_mem_flush = ctrl.ex_mem_flush;
  assign bus.mem_wb_flush = ctrl.mem_wb_flush;
  assign bus.mdu_busy     = mdu_busy;

endmodule
